// File: rtl/guvm_dmem_responder.sv
// rtl/guvm_dmem_responder.sv - data-port memory responder with grant latency, response pipe and outstanding cap
// Optional GUVM_DMEM_ERR_EN adds data_err_o and out-of-range address detection.
module guvm_dmem_responder #(
  parameter int AW       = 10,
  parameter int GNT_LAT  = 0,
  parameter int RESP_LAT = 1,
  parameter int MAX_OUT  = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o
`ifdef GUVM_DMEM_ERR_EN
  ,
  output logic        data_err_o
`endif
);

  localparam int CW = 4;
  localparam int OW = 4;
  localparam logic [CW-1:0] CNT_INIT = (GNT_LAT > 0) ? CW'(GNT_LAT - 1) : '0;
  localparam logic [OW-1:0] OUT_CAP  = OW'(MAX_OUT);
`ifdef GUVM_DMEM_ERR_EN
  localparam int SW = 34;
`else
  localparam int SW = 33;
`endif

  typedef enum logic {IDLE, WAIT} state_t;

  state_t                     state, state_nxt;
  logic [CW-1:0]              cnt, cnt_nxt;
  logic [OW-1:0]              outstanding;
  logic                       gnt_raw;
  logic                       full;
  logic                       hs;
  logic                       oor;
  logic                       mem_we;
  logic [AW-1:0]              idx;
  logic [31:0]                bmask;
  logic [31:0]                rd_word;
  logic [SW-1:0]              push;
  logic [RESP_LAT-1:0][SW-1:0] stage;
  logic [31:0]                mem [2**AW];

  assign idx = data_addr_i[AW+1:2];

`ifdef GUVM_DMEM_ERR_EN
  logic unused_addr_bits;
  assign unused_addr_bits = ^data_addr_i[1:0];
  assign oor              = |data_addr_i[31:AW+2];
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{data_addr_i[31:AW+2], data_addr_i[1:0]};
  assign oor              = 1'b0;
`endif

  // A retiring response frees its slot in the same cycle it leaves.
  assign full = (outstanding == OUT_CAP) & ~data_rvalid_o;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    gnt_raw   = 1'b0;
    case (state)
      IDLE: begin
        if (GNT_LAT == 0) begin
          gnt_raw = data_req_i & ~full;
        end else if (data_req_i) begin
          state_nxt = WAIT;
          cnt_nxt   = CNT_INIT;
        end
      end
      WAIT: begin
        if (!data_req_i) begin
          state_nxt = IDLE;
        end else if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          gnt_raw = ~full;
          if (!full) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign data_gnt_o = gnt_raw & ~rst_i;
  assign hs         = data_req_i & data_gnt_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outstanding <= '0;
    end else begin
      case ({hs, data_rvalid_o})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Memory contents deliberately survive reset.
  assign bmask   = {{8{data_be_i[3]}}, {8{data_be_i[2]}}, {8{data_be_i[1]}}, {8{data_be_i[0]}}};
  assign mem_we  = hs & data_we_i & ~oor;
  assign rd_word = oor ? 32'h0 : mem[idx];

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[idx] <= (mem[idx] & ~bmask) | (data_wdata_i & bmask);
    end
  end

  // Entry layout: [31:0] rdata, [32] valid, [33] err when enabled.
  always_comb begin
    push        = '0;
    push[32]    = hs;
    push[31:0]  = (hs && !data_we_i) ? rd_word : 32'h0;
`ifdef GUVM_DMEM_ERR_EN
    push[33]    = hs & oor;
`endif
  end

  if (RESP_LAT == 1) begin : g_pipe_one
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) stage <= '0;
      else       stage <= push;
    end
  end else begin : g_pipe_many
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) stage <= '0;
      else       stage <= {stage[RESP_LAT-2:0], push};
    end
  end

  assign data_rvalid_o = stage[RESP_LAT-1][32];
  assign data_rdata_o  = stage[RESP_LAT-1][31:0];
`ifdef GUVM_DMEM_ERR_EN
  assign data_err_o    = stage[RESP_LAT-1][33];
`endif

endmodule

// File: tb/tb_guvm_dmem_responder.sv
// tb/tb_guvm_dmem_responder.sv - self-checking bench over four responder configurations
// Scoreboard predicts grants, response timing and data from a flat memory model.
`timescale 1ns/1ps
module tb_guvm_dmem_responder;

  localparam int NI = 4;

  function automatic int p_gl(input int i);
    case (i)
      1:       return 3;
      default: return 0;
    endcase
  endfunction
  function automatic int p_rl(input int i);
    case (i)
      0:       return 1;
      1:       return 2;
      2:       return 4;
      default: return 3;
    endcase
  endfunction
  function automatic int p_mo(input int i);
    case (i)
      2:       return 1;
      3:       return 3;
      default: return 2;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req    [NI];
  logic        we     [NI];
  logic [3:0]  be     [NI];
  logic [31:0] addr   [NI];
  logic [31:0] wdata  [NI];
  logic        gnt    [NI];
  logic        rvalid [NI];
  logic [31:0] rdata  [NI];
  logic        err    [NI];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    guvm_dmem_responder #(
      .AW(10), .GNT_LAT(p_gl(g)), .RESP_LAT(p_rl(g)), .MAX_OUT(p_mo(g))
    ) u_dut (
      .clk_i(clk), .rst_i(rst),
      .data_req_i(req[g]), .data_gnt_o(gnt[g]),
      .data_we_i(we[g]), .data_be_i(be[g]),
      .data_addr_i(addr[g]), .data_wdata_i(wdata[g]),
      .data_rvalid_o(rvalid[g]), .data_rdata_o(rdata[g])
`ifdef GUVM_DMEM_ERR_EN
      , .data_err_o(err[g])
`endif
    );
`ifndef GUVM_DMEM_ERR_EN
    assign err[g] = 1'b0;
`endif
  end

  // Reference model: word memory, expected-response FIFO, observed response log.
  logic [31:0] mmem  [NI][1024];
  bit          known [NI][1024];
  int          rsp_due  [NI][16];
  logic [31:0] rsp_dat  [NI][16];
  logic        rsp_err  [NI][16];
  bit          rsp_chk  [NI][16];
  int          rhead [NI];
  int          rtail [NI];
  int          held  [NI];
  int          obs_out [NI];
  int          lg_cyc [NI][128];
  logic [31:0] lg_dat [NI][128];
  logic        lg_err [NI][128];
  int          lg_n   [NI];

  always @(negedge clk) begin : mon
    int n, s, ix;
    bit exp_rv, full_m, exp_g, oor_m;
    logic [31:0] bm;
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        rhead[i] = 0; rtail[i] = 0; held[i] = 0; obs_out[i] = 0;
      end else begin
        n = rtail[i] - rhead[i];
        s = rhead[i] & 15;
        exp_rv = (n > 0) && (rsp_due[i][s] == cyc);
        total++;
        if (rvalid[i] !== exp_rv) begin
          bad++;
          $display("FAIL rvalid_timing inst=%0d cyc=%0d got=%b want=%b", i, cyc, rvalid[i], exp_rv);
        end
        if (rvalid[i] === 1'b1) begin
          if (lg_n[i] < 128) begin
            lg_cyc[i][lg_n[i]] = cyc; lg_dat[i][lg_n[i]] = rdata[i]; lg_err[i][lg_n[i]] = err[i];
            lg_n[i]++;
          end
          if (n > 0) begin
            if (rsp_chk[i][s]) begin
              total++;
              if (rdata[i] !== rsp_dat[i][s]) begin
                bad++;
                $display("FAIL rdata inst=%0d cyc=%0d got=%h want=%h", i, cyc, rdata[i], rsp_dat[i][s]);
              end
            end
`ifdef GUVM_DMEM_ERR_EN
            total++;
            if (err[i] !== rsp_err[i][s]) begin
              bad++;
              $display("FAIL err inst=%0d cyc=%0d got=%b want=%b", i, cyc, err[i], rsp_err[i][s]);
            end
`endif
            rhead[i]++;
          end
        end else begin
          if (exp_rv) rhead[i]++;
          total++;
          if (rdata[i] !== 32'h0 || err[i] !== 1'b0) begin
            bad++;
            $display("FAIL idle_outputs inst=%0d cyc=%0d rdata=%h err=%b want 0/0", i, cyc, rdata[i], err[i]);
          end
        end
        full_m = (n == p_mo(i)) && !exp_rv;
        exp_g  = req[i] && (held[i] >= p_gl(i)) && !full_m;
        total++;
        if (gnt[i] !== exp_g) begin
          bad++;
          $display("FAIL gnt inst=%0d cyc=%0d got=%b want=%b held=%0d out=%0d", i, cyc, gnt[i], exp_g, held[i], n);
        end
        if (req[i] === 1'b1 && gnt[i] === 1'b1) begin
          ix = int'(addr[i][11:2]);
`ifdef GUVM_DMEM_ERR_EN
          oor_m = (addr[i][31:12] != 20'h0);
`else
          oor_m = 1'b0;
`endif
          s = rtail[i] & 15;
          rsp_due[i][s] = cyc + p_rl(i);
          rsp_err[i][s] = oor_m;
          if (we[i]) begin
            if (!oor_m) begin
              bm = {{8{be[i][3]}}, {8{be[i][2]}}, {8{be[i][1]}}, {8{be[i][0]}}};
              mmem[i][ix] = (mmem[i][ix] & ~bm) | (wdata[i] & bm);
              if (be[i] == 4'hF) known[i][ix] = 1'b1;
            end
            rsp_dat[i][s] = 32'h0; rsp_chk[i][s] = 1'b1;
          end else begin
            rsp_dat[i][s] = oor_m ? 32'h0 : mmem[i][ix];
            rsp_chk[i][s] = oor_m || known[i][ix];
          end
          rtail[i]++;
          obs_out[i]++;
        end
        if (rvalid[i] === 1'b1) obs_out[i]--;
        total++;
        if (obs_out[i] > p_mo(i)) begin
          bad++;
          $display("FAIL outstanding inst=%0d cyc=%0d got=%0d max=%0d", i, cyc, obs_out[i], p_mo(i));
        end
        if (req[i] !== 1'b1 || gnt[i] === 1'b1) held[i] = 0;
        else held[i]++;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic issue(input int i, input bit w, input logic [3:0] b, input logic [31:0] a,
                       input logic [31:0] d, output int gcyc);
    int k;
    k = 0; gcyc = -1;
    req[i] = 1'b1; we[i] = w; be[i] = b; addr[i] = a; wdata[i] = d;
    while (gcyc < 0 && k < 60) begin
      @(negedge clk);
      if (gnt[i] === 1'b1) gcyc = cyc;
      @(posedge clk); #1;
      k++;
    end
    req[i] = 1'b0;
    if (gcyc < 0) begin
      total++; bad++;
      $display("FAIL gnt_timeout inst=%0d addr=%h got=none want=gnt", i, a);
    end
  endtask

  task automatic test_reset();
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h0;
    idle(2);
    @(negedge clk);
    total++;
    if (gnt[0] !== 1'b0) begin bad++; $display("FAIL reset_gnt got=%b want=0", gnt[0]); end
    for (int i = 0; i < NI; i++) begin
      total++;
      if (rvalid[i] !== 1'b0 || rdata[i] !== 32'h0 || err[i] !== 1'b0) begin
        bad++;
        $display("FAIL reset_outputs inst=%0d rvalid=%b rdata=%h err=%b want 0", i, rvalid[i], rdata[i], err[i]);
      end
    end
    req[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_defaults();
    int t0, gw, gr;
    lg_n[0] = 0;
    t0 = cyc;
    issue(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, gw);
    issue(0, 1'b0, 4'hF, 32'h10, 32'h0, gr);
    idle(3);
    total++;
    if (gw != t0 || gr != t0 + 1) begin
      bad++; $display("FAIL defaults_gnt got=%0d,%0d want=%0d,%0d", gw, gr, t0, t0 + 1);
    end
    total++;
    if (lg_n[0] != 2 || lg_cyc[0][0] != gw + 1 || lg_dat[0][0] !== 32'h0) begin
      bad++; $display("FAIL defaults_wrsp n=%0d cyc=%0d dat=%h want 2/%0d/0", lg_n[0], lg_cyc[0][0], lg_dat[0][0], gw + 1);
    end
    total++;
    if (lg_cyc[0][1] != gr + 1 || lg_dat[0][1] !== 32'hDEADBEEF) begin
      bad++; $display("FAIL defaults_rrsp cyc=%0d dat=%h want %0d/deadbeef", lg_cyc[0][1], lg_dat[0][1], gr + 1);
    end
  endtask

  task automatic test_byte_en();
    int g;
    lg_n[0] = 0;
    issue(0, 1'b1, 4'hF, 32'h20, 32'h11223344, g);
    issue(0, 1'b1, 4'b0101, 32'h20, 32'hAABBCCDD, g);
    issue(0, 1'b0, 4'hF, 32'h20, 32'h0, g);
    issue(0, 1'b1, 4'h0, 32'h20, 32'hFFFFFFFF, g);
    issue(0, 1'b0, 4'hF, 32'h20, 32'h0, g);
    idle(3);
    total++;
    if (lg_n[0] != 5 || lg_dat[0][2] !== 32'h11BB33DD) begin
      bad++; $display("FAIL byte_en got=%h n=%0d want=11bb33dd", lg_dat[0][2], lg_n[0]);
    end
    total++;
    if (lg_dat[0][4] !== 32'h11BB33DD) begin
      bad++; $display("FAIL be_zero_noop got=%h want=11bb33dd", lg_dat[0][4]);
    end
  endtask

  task automatic test_grant_latency();
    int t0, g;
    issue(1, 1'b1, 4'hF, 32'h30, 32'hCAFEF00D, g);
    idle(4);
    lg_n[1] = 0;
    t0 = cyc;
    req[1] = 1'b1; we[1] = 1'b0; be[1] = 4'hF; addr[1] = 32'h30;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if (gnt[1] !== 1'(k == 3)) begin
        bad++; $display("FAIL gnt_lat cycle=%0d got=%b want=%b", k, gnt[1], (k == 3));
      end
      @(posedge clk); #1;
    end
    req[1] = 1'b0;
    idle(4);
    total++;
    if (lg_n[1] != 1 || lg_cyc[1][0] != t0 + 5 || lg_dat[1][0] !== 32'hCAFEF00D) begin
      bad++; $display("FAIL gnt_lat_rsp n=%0d cyc=%0d dat=%h want 1/%0d/cafef00d", lg_n[1], lg_cyc[1][0], lg_dat[1][0], t0 + 5);
    end
    lg_n[1] = 0;
    req[1] = 1'b1;
    @(posedge clk); #1;
    req[1] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      total++;
      if (gnt[1] !== 1'b0) begin bad++; $display("FAIL drop_gnt cycle=%0d got=%b want=0", k, gnt[1]); end
      @(posedge clk); #1;
    end
    total++;
    if (lg_n[1] != 0) begin bad++; $display("FAIL drop_rvalid got=%0d want=0", lg_n[1]); end
  endtask

  task automatic test_max_out();
    int t0;
    int g [3];
    for (int j = 0; j < 3; j++) issue(2, 1'b1, 4'hF, 32'(4 * j), 32'hA0 + 32'(j), g[0]);
    idle(6);
    lg_n[2] = 0;
    t0 = cyc;
    for (int j = 0; j < 3; j++) issue(2, 1'b0, 4'hF, 32'(4 * j), 32'h0, g[j]);
    idle(6);
    for (int j = 0; j < 3; j++) begin
      total++;
      if (g[j] != t0 + 4 * j || lg_cyc[2][j] != t0 + 4 * j + 4 || lg_dat[2][j] !== 32'hA0 + 32'(j)) begin
        bad++;
        $display("FAIL max_out j=%0d gnt=%0d rv=%0d dat=%h want %0d/%0d/%h", j, g[j], lg_cyc[2][j], lg_dat[2][j],
                 t0 + 4 * j, t0 + 4 * j + 4, 32'hA0 + 32'(j));
      end
    end
  endtask

  task automatic test_reset_midflight();
    int g, t1;
    issue(3, 1'b1, 4'hF, 32'h40, 32'h5EED1234, g);
    idle(5);
    lg_n[3] = 0;
    issue(3, 1'b0, 4'hF, 32'h40, 32'h0, g);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(6);
    total++;
    if (lg_n[3] != 0) begin bad++; $display("FAIL reset_drop got=%0d rvalids want=0", lg_n[3]); end
    t1 = cyc;
    issue(3, 1'b0, 4'hF, 32'h40, 32'h0, g);
    idle(5);
    total++;
    if (g != t1 || lg_n[3] != 1 || lg_cyc[3][0] != g + 3 || lg_dat[3][0] !== 32'h5EED1234) begin
      bad++; $display("FAIL reset_resume gnt=%0d n=%0d dat=%h want %0d/1/5eed1234", g, lg_n[3], lg_dat[3][0], t1);
    end
  endtask

  task automatic test_err_range();
    int g;
    lg_n[0] = 0;
    issue(0, 1'b1, 4'hF, 32'h0, 32'h12345678, g);
    issue(0, 1'b1, 4'hF, 32'h1000, 32'h5A, g);
    issue(0, 1'b0, 4'hF, 32'h1000, 32'h0, g);
    issue(0, 1'b0, 4'hF, 32'h0, 32'h0, g);
    idle(3);
    total++;
    if (lg_n[0] != 4) begin bad++; $display("FAIL err_count got=%0d want=4", lg_n[0]); end
`ifdef GUVM_DMEM_ERR_EN
    total++;
    if (lg_err[0][0] !== 1'b0 || lg_err[0][1] !== 1'b1) begin
      bad++; $display("FAIL err_write got=%b,%b want=0,1", lg_err[0][0], lg_err[0][1]);
    end
    total++;
    if (lg_err[0][2] !== 1'b1 || lg_dat[0][2] !== 32'h0) begin
      bad++; $display("FAIL err_read got=%b/%h want=1/0", lg_err[0][2], lg_dat[0][2]);
    end
    total++;
    if (lg_err[0][3] !== 1'b0 || lg_dat[0][3] !== 32'h12345678) begin
      bad++; $display("FAIL err_inrange got=%b/%h want=0/12345678", lg_err[0][3], lg_dat[0][3]);
    end
`else
    total++;
    if (lg_dat[0][2] !== 32'h5A || lg_dat[0][3] !== 32'h5A) begin
      bad++; $display("FAIL alias got=%h,%h want=5a,5a", lg_dat[0][2], lg_dat[0][3]);
    end
`endif
  endtask

  task automatic rand_stream(input int i, input int n);
    int g, k;
    logic [31:0] a;
    for (int j = 0; j < 8; j++) issue(i, 1'b1, 4'hF, 32'h200 + 32'(4 * j), $urandom, g);
    for (int t = 0; t < n; t++) begin
      k = $urandom_range(0, 7);
      a = 32'h200 + 32'(4 * k);
      if ($urandom_range(0, 7) == 0) a = a | (32'($urandom_range(1, 15)) << 12);
      issue(i, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom, g);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_random();
    fork
      rand_stream(0, 80);
      rand_stream(1, 60);
      rand_stream(2, 40);
      rand_stream(3, 80);
    join
    idle(12);
    for (int i = 0; i < NI; i++) begin
      total++;
      if (rtail[i] != rhead[i] || obs_out[i] != 0) begin
        bad++; $display("FAIL drain inst=%0d pending=%0d out=%0d want=0", i, rtail[i] - rhead[i], obs_out[i]);
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NI; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; be[i] = 4'h0; addr[i] = 32'h0; wdata[i] = 32'h0;
      lg_n[i] = 0; rhead[i] = 0; rtail[i] = 0; held[i] = 0; obs_out[i] = 0;
    end
    @(posedge clk); #1;
    test_reset();
    test_defaults();
    test_byte_en();
    test_grant_latency();
    test_max_out();
    test_reset_midflight();
    test_err_range();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
